// File: rtl/return_addr_stack.sv
// return_addr_stack: circular LIFO of link addresses used to predict JR targets
module return_addr_stack #(
    parameter int DataWidth = 16,
    parameter int Depth     = 4,
    parameter int PtrBits   = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 clear,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_addr,
    input  logic                 pop,
    output logic [DataWidth-1:0] top_addr,
    output logic                 valid,
    output logic                 full,
    output logic                 underflow,
    output logic                 overflow
);
    localparam logic [PtrBits:0] CntFull = (PtrBits+1)'(Depth);
    localparam logic [PtrBits:0] CntOne  = (PtrBits+1)'(1);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrBits-1:0]   tp, tp_nxt;
    logic [PtrBits:0]     cnt, cnt_nxt;
    logic                 we, uf_nxt, of_nxt;

    assign valid    = cnt != '0;
    assign full     = cnt == CntFull;
    assign top_addr = valid ? mem[tp] : '0;

    // Next pointer/count, write enable and pulse values by priority: clear, replace-top, push, pop
    always_comb begin
        tp_nxt  = tp;
        cnt_nxt = cnt;
        we      = 1'b0;
        uf_nxt  = 1'b0;
        of_nxt  = 1'b0;
        if (clear) begin
            tp_nxt  = '0;
            cnt_nxt = '0;
        end else if (push && pop && valid) begin
            we = 1'b1;
        end else if (push) begin
            we      = 1'b1;
            tp_nxt  = valid ? tp + 1'b1 : tp;
            cnt_nxt = full ? cnt : cnt + 1'b1;
            of_nxt  = full;
        end else if (pop) begin
            uf_nxt  = !valid;
            cnt_nxt = valid ? cnt - 1'b1 : cnt;
            tp_nxt  = (valid && cnt != CntOne) ? tp - 1'b1 : tp;
        end
    end

    // Stack state register; an overflowing push lands on the oldest slot after the wrap
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tp        <= '0;
            cnt       <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            tp        <= tp_nxt;
            cnt       <= cnt_nxt;
            underflow <= uf_nxt;
            overflow  <= of_nxt;
            if (we) mem[tp_nxt] <= push_addr;
        end
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed checks of the return-address stack with hand-computed values
module tb_return_addr_stack;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        clear = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [15:0] push_addr = '0;
    logic [15:0] top_addr;
    logic        valid, full, underflow, overflow;
    int          n_chk = 0;
    int          n_fail = 0;

    return_addr_stack #(.DataWidth(16), .Depth(4), .PtrBits(2)) dut (
        .CLK(CLK), .RST(RST), .clear(clear), .push(push), .push_addr(push_addr),
        .pop(pop), .top_addr(top_addr), .valid(valid), .full(full),
        .underflow(underflow), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic [15:0] a, input logic q, input logic c);
        push = p;
        push_addr = a;
        pop = q;
        clear = c;
        @(posedge CLK);
        #1;
        push = 1'b0;
        pop = 1'b0;
        clear = 1'b0;
    endtask

    task automatic state(input string tag, input logic [15:0] t, input logic v, input logic f,
                         input logic u, input logic o);
        chk({tag, ".top"}, {16'h0, top_addr}, {16'h0, t});
        chk({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
        chk({tag, ".full"}, {31'h0, full}, {31'h0, f});
        chk({tag, ".underflow"}, {31'h0, underflow}, {31'h0, u});
        chk({tag, ".overflow"}, {31'h0, overflow}, {31'h0, o});
    endtask

    initial begin
        #2;
        state("reset", 16'h0000, 0, 0, 0, 0);
        #8;
        RST = 1'b1;
        // basic LIFO
        cyc(1, 16'h0003, 0, 0); state("push3", 16'h0003, 1, 0, 0, 0);
        cyc(1, 16'h0005, 0, 0); state("push5", 16'h0005, 1, 0, 0, 0);
        cyc(1, 16'h0007, 0, 0); state("push7", 16'h0007, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("pop1", 16'h0005, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("pop2", 16'h0003, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("pop3", 16'h0000, 0, 0, 0, 0);
        // overflow wraps and loses the oldest entry
        cyc(1, 16'h0001, 0, 0); state("ov_p1", 16'h0001, 1, 0, 0, 0);
        cyc(1, 16'h0002, 0, 0); state("ov_p2", 16'h0002, 1, 0, 0, 0);
        cyc(1, 16'h0003, 0, 0); state("ov_p3", 16'h0003, 1, 0, 0, 0);
        cyc(1, 16'h0004, 0, 0); state("ov_p4", 16'h0004, 1, 1, 0, 0);
        cyc(1, 16'h0005, 0, 0); state("ov_p5", 16'h0005, 1, 1, 0, 1);
        cyc(0, 16'h0000, 1, 0); state("ov_pop1", 16'h0004, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("ov_pop2", 16'h0003, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("ov_pop3", 16'h0002, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("ov_pop4", 16'h0000, 0, 0, 0, 0);
        // underflow pulse
        cyc(0, 16'h0000, 1, 0); state("uf_pop", 16'h0000, 0, 0, 1, 0);
        cyc(0, 16'h0000, 0, 0); state("uf_idle", 16'h0000, 0, 0, 0, 0);
        cyc(1, 16'h00AA, 0, 0); state("uf_push", 16'h00AA, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("uf_drain", 16'h0000, 0, 0, 0, 0);
        // push & pop replaces top; on empty it acts as push
        cyc(1, 16'h0010, 0, 0); state("pp_push", 16'h0010, 1, 0, 0, 0);
        cyc(1, 16'h0020, 1, 0); state("pp_rep", 16'h0020, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("pp_pop", 16'h0000, 0, 0, 0, 0);
        cyc(1, 16'h0030, 1, 0); state("pp_empty", 16'h0030, 1, 0, 0, 0);
        cyc(0, 16'h0000, 1, 0); state("pp_drain", 16'h0000, 0, 0, 0, 0);
        // clear beats push
        cyc(1, 16'h0011, 0, 0); state("cl_p1", 16'h0011, 1, 0, 0, 0);
        cyc(1, 16'h0022, 0, 0); state("cl_p2", 16'h0022, 1, 0, 0, 0);
        cyc(1, 16'h0033, 0, 1); state("cl_clr", 16'h0000, 0, 0, 0, 0);
        cyc(1, 16'h0044, 0, 0); state("cl_push", 16'h0044, 1, 0, 0, 0);
        // async reset during a push
        push = 1'b1;
        push_addr = 16'h0055;
        #2;
        RST = 1'b0;
        #1;
        state("rst_async", 16'h0000, 0, 0, 0, 0);
        @(posedge CLK);
        #1;
        state("rst_hold", 16'h0000, 0, 0, 0, 0);
        push = 1'b0;
        RST = 1'b1;
        cyc(0, 16'h0000, 0, 0); state("rst_rel", 16'h0000, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
